// File: rtl/mp_reg_file.sv
// mp_reg_file: multi-ported register file with a per-register busy scoreboard.
// Two write ports (ALU and memory writeback), two registered read ports that
// bypass same-cycle writes, and a set_busy port that marks a register as the
// pending destination of an issued instruction.
module mp_reg_file #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned NREGS   = 8,
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned SP_IDX  = 0,
   parameter logic [63:0] SP_INIT = 64'h1FFC
) (
   input  logic              clk,
   input  logic              reset,
   // Read ports
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_busy_a,
   output logic              rd_busy_b,
   // Write port 0 (ALU writeback)
   input  logic              wr0_en,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   // Write port 1 (memory writeback)
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   // Scoreboard
   input  logic              set_busy,
   input  logic [ADDR_W-1:0] set_addr,
   output logic [NREGS-1:0]  busy_vec
);

   localparam logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_INIT);
   localparam int unsigned       SP_SLOT  = SP_IDX % NREGS;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  busy_q;
   logic [NREGS-1:0]  busy_d;

   logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;
   logic              rd_busy_a_q, rd_busy_b_q;

   // Next register/scoreboard state; port 1 applied last so it wins on a
   // shared address, and set_busy applied after the clears so a new producer wins.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr0_en) begin
         regs_d[wr0_addr] = wr0_data;
         busy_d[wr0_addr] = 1'b0;
      end
      if (wr1_en) begin
         regs_d[wr1_addr] = wr1_data;
         busy_d[wr1_addr] = 1'b0;
      end
      if (set_busy) begin
         busy_d[set_addr] = 1'b1;
      end
   end

   // State update; reads sample the post-write view, which gives the bypass for free.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == SP_SLOT) ? SP_RESET : '0;
         end
         busy_q      <= '0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_busy_a_q <= 1'b0;
         rd_busy_b_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         if (rd_en) begin
            rd_data_a_q <= regs_d[rd_addr_a];
            rd_data_b_q <= regs_d[rd_addr_b];
            rd_busy_a_q <= busy_d[rd_addr_a];
            rd_busy_b_q <= busy_d[rd_addr_b];
         end
      end
   end

   // Outputs straight from state.
   always_comb begin
      rd_data_a = rd_data_a_q;
      rd_data_b = rd_data_b_q;
      rd_busy_a = rd_busy_a_q;
      rd_busy_b = rd_busy_b_q;
      busy_vec  = busy_q;
   end

endmodule

// File: tb/tb_mp_reg_file.sv
// Scoreboard bench for mp_reg_file: each directed step pushes its hand-computed
// post-edge outputs; a monitor pops one entry per clock edge and compares.
module tb_mp_reg_file;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_en;
   logic [2:0]  rd_addr_a, rd_addr_b;
   logic [15:0] rd_data_a, rd_data_b;
   logic        rd_busy_a, rd_busy_b;
   logic        wr0_en, wr1_en, set_busy;
   logic [2:0]  wr0_addr, wr1_addr, set_addr;
   logic [15:0] wr0_data, wr1_data;
   logic [7:0]  busy_vec;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        ba;
      logic        bb;
      logic [7:0]  vec;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   mp_reg_file dut (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rd_busy_a (rd_busy_a),
      .rd_busy_b (rd_busy_b),
      .wr0_en    (wr0_en),
      .wr0_addr  (wr0_addr),
      .wr0_data  (wr0_data),
      .wr1_en    (wr1_en),
      .wr1_addr  (wr1_addr),
      .wr1_data  (wr1_data),
      .set_busy  (set_busy),
      .set_addr  (set_addr),
      .busy_vec  (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int step, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
      end
   endtask

   // Monitor: every edge with a pending expectation yields one full comparison.
   initial begin : monitor
      int n = 0;
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n++;
            chk("rd_data_a", n, rd_data_a, e.a);
            chk("rd_data_b", n, rd_data_b, e.b);
            chk("rd_busy_a", n, {15'd0, rd_busy_a}, {15'd0, e.ba});
            chk("rd_busy_b", n, {15'd0, rd_busy_b}, {15'd0, e.bb});
            chk("busy_vec",  n, {8'd0, busy_vec},   {8'd0, e.vec});
         end
      end
   end

   // One cycle of stimulus plus the outputs expected right after its edge.
   task automatic step(input logic rst, input logic ren, input logic [2:0] ra,
                       input logic [2:0] rb, input logic w0e, input logic [2:0] w0a,
                       input logic [15:0] w0d, input logic w1e, input logic [2:0] w1a,
                       input logic [15:0] w1d, input logic sb, input logic [2:0] sa,
                       input logic [15:0] ea, input logic [15:0] eb, input logic eba,
                       input logic ebb, input logic [7:0] evec);
      exp_t e;
      @(negedge clk);
      reset = rst; rd_en = ren; rd_addr_a = ra; rd_addr_b = rb;
      wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
      wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
      set_busy = sb; set_addr = sa;
      e.a = ea; e.b = eb; e.ba = eba; e.bb = ebb; e.vec = evec;
      exp_q.push_back(e);
   endtask

   initial begin : stimulus
      reset = 1'b1; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      set_busy = 1'b0; set_addr = '0;

      //   rst ren ra rb  w0e w0a w0d       w1e w1a w1d       sb sa   exp a     exp b     ba bb vec
      // Reset overrides a write, set_busy and a read
      step(1, 1, 3, 4,  1, 3, 16'h5555,  0, 0, 16'h0000,  1, 4,  16'h0000, 16'h0000, 0, 0, 8'h00);
      // Reset values: SP and a plain register
      step(0, 1, 0, 5,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h1FFC, 16'h0000, 0, 0, 8'h00);
      // Write during reset left no trace in r3 or r4's busy bit
      step(0, 1, 3, 4,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h0000, 16'h0000, 0, 0, 8'h00);
      // wr0 bypass into port A
      step(0, 1, 3, 0,  1, 3, 16'h00AA,  0, 0, 16'h0000,  0, 0,  16'h00AA, 16'h1FFC, 0, 0, 8'h00);
      step(0, 1, 3, 3,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h00AA, 16'h00AA, 0, 0, 8'h00);
      // Dual write to r2: port 1 wins, bypassed on port B
      step(0, 1, 3, 2,  1, 2, 16'h1111,  1, 2, 16'h2222,  0, 0,  16'h00AA, 16'h2222, 0, 0, 8'h00);
      step(0, 1, 2, 2,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h2222, 16'h2222, 0, 0, 8'h00);
      // Scoreboard: set r4, clear by wr1, then set+write together
      step(0, 1, 4, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 4,  16'h0000, 16'h1FFC, 1, 0, 8'h10);
      step(0, 1, 4, 4,  0, 0, 16'h0000,  1, 4, 16'h4444,  0, 0,  16'h4444, 16'h4444, 0, 0, 8'h00);
      step(0, 1, 4, 3,  1, 4, 16'h0A0A,  0, 0, 16'h0000,  1, 4,  16'h0A0A, 16'h00AA, 1, 0, 8'h10);
      step(0, 1, 4, 1,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h0A0A, 16'h0000, 1, 0, 8'h10);
      // rd_en low for 3 cycles while r1 is rewritten: outputs hold
      step(0, 0, 1, 1,  1, 1, 16'h0001,  0, 0, 16'h0000,  0, 0,  16'h0A0A, 16'h0000, 1, 0, 8'h10);
      step(0, 0, 1, 1,  1, 1, 16'h0002,  0, 0, 16'h0000,  0, 0,  16'h0A0A, 16'h0000, 1, 0, 8'h10);
      step(0, 0, 1, 1,  1, 1, 16'h0003,  0, 0, 16'h0000,  0, 0,  16'h0A0A, 16'h0000, 1, 0, 8'h10);
      step(0, 1, 1, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h0003, 16'h1FFC, 0, 0, 8'h10);
      // SP is an ordinary writable register
      step(0, 1, 0, 7,  1, 0, 16'hBEEF,  0, 0, 16'h0000,  0, 0,  16'hBEEF, 16'h0000, 0, 0, 8'h10);
      // Fill the scoreboard with reads held
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 0,  16'hBEEF, 16'h0000, 0, 0, 8'h11);
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 1,  16'hBEEF, 16'h0000, 0, 0, 8'h13);
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 2,  16'hBEEF, 16'h0000, 0, 0, 8'h17);
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 3,  16'hBEEF, 16'h0000, 0, 0, 8'h1F);
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 5,  16'hBEEF, 16'h0000, 0, 0, 8'h3F);
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 6,  16'hBEEF, 16'h0000, 0, 0, 8'h7F);
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 7,  16'hBEEF, 16'h0000, 0, 0, 8'hFF);
      // Reading busy registers before reset
      step(0, 1, 2, 7,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h2222, 16'h0000, 1, 1, 8'hFF);
      // Mid-operation reset with active writes and set_busy
      step(1, 1, 5, 6,  1, 5, 16'h5555,  1, 6, 16'h6666,  1, 3,  16'h0000, 16'h0000, 0, 0, 8'h00);
      step(0, 1, 0, 5,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h1FFC, 16'h0000, 0, 0, 8'h00);
      step(0, 1, 6, 1,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h0000, 16'h0000, 0, 0, 8'h00);
      // Busy read cleared by a same-cycle write to the read address
      step(0, 0, 7, 7,  0, 0, 16'h0000,  0, 0, 16'h0000,  1, 7,  16'h0000, 16'h0000, 0, 0, 8'h80);
      step(0, 1, 7, 6,  0, 0, 16'h0000,  1, 7, 16'h7777,  1, 6,  16'h7777, 16'h0000, 0, 1, 8'h40);
      // Two writes to different registers clear both busy bits
      step(0, 1, 6, 7,  1, 6, 16'h0606,  1, 7, 16'h0707,  0, 0,  16'h0606, 16'h0707, 0, 0, 8'h00);

      // Idle a few cycles and confirm every expectation was consumed
      step(0, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 16'h0000,  0, 0,  16'h0606, 16'h0707, 0, 0, 8'h00);
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
